jstk_spi_responder: RTL and testbench
=====================================

JSTK_SPI_RESPONDER -- requirements
Module: jstk_spi_responder

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset; all state is clocked on the rising edge of Clk.
REQ-002 SHALL have port `Clk` (input, 1): system clock; frequency at least 8x the SCLK frequency.
REQ-003 SHALL have port `Reset` (input, 1): synchronous active-high reset.
REQ-004 SHALL have port `SS` (input, 1): slave select from the SPI master, active low, asynchronous to Clk.
REQ-005 SHALL have port `SCLK` (input, 1): SPI clock, mode 0 (idle low), asynchronous to Clk.
REQ-006 SHALL have port `MOSI` (input, 1): master-to-slave data, MSB first.
REQ-007 SHALL have port `MISO` (output, 1): slave-to-master data, MSB first; never tri-stated.
REQ-008 SHALL have port `X_Pos` (input, 10): X position to report.
REQ-009 SHALL have port `Y_Pos` (input, 10): Y position to report.
REQ-010 SHALL have port `Buttons` (input, 3): button state to report.
REQ-011 SHALL have port `Led_Cmd` (output, 2): last accepted LED command bits.
REQ-012 SHALL have port `Frame_Done` (output, 1): 1-Clk pulse when a well-formed 40-bit frame ends.
REQ-013 SHALL have port `Frame_Error` (output, 1): 1-Clk pulse when a frame ends with a bit count other than 40.

Function
REQ-014 SHALL pass SS, SCLK and MOSI each through a 2-flop synchronizer, then through a 1-flop edge-detect stage; all protocol decisions SHALL use the synchronized signals only.
REQ-015 SHALL implement a three-state FSM with states IDLE, SHIFT and REPORT.
REQ-016 IDLE -> SHIFT on a synchronized SS falling edge; SHIFT -> REPORT on a synchronized SS rising edge; REPORT -> IDLE after exactly 1 cycle.
REQ-017 On the SS falling edge, the block SHALL snapshot a 40-bit TX frame, first byte first: {X_Pos[7:0], 6'b0, X_Pos[9:8], Y_Pos[7:0], 6'b0, Y_Pos[9:8], 5'b0, Buttons}.
REQ-018 Input changes after the snapshot SHALL NOT affect the frame in flight.
REQ-019 On the snapshot cycle, the block SHALL clear the bit counter (6 bits) and the RX byte register.
REQ-020 In SHIFT, the MSB of the TX frame (frame bit 39) SHALL appear on MISO within 1 Clk of the snapshot.
REQ-021 In SHIFT, on each synchronized SCLK rising edge: shift MOSI into the RX byte LSB; increment the bit counter, saturating at 41.
REQ-022 In SHIFT, on each synchronized SCLK falling edge: shift the TX frame left by 1, filling with 0; MISO follows the new MSB.
REQ-023 After 40 bits, MISO SHALL be 0.
REQ-024 When the bit counter reaches 8, if RX byte bit 7 = 1, Led_Cmd SHALL load RX byte bits [1:0] on the next cycle.
REQ-025 When the bit counter reaches 8 and RX byte bit 7 = 0, Led_Cmd SHALL hold its value.
REQ-026 RX bits after bit 8 SHALL be ignored.
REQ-027 In REPORT, the block SHALL pulse Frame_Done for 1 cycle if the bit counter = 40.
REQ-028 In REPORT, the block SHALL pulse Frame_Error for 1 cycle if the bit counter is anything other than 40 (short frame, or overrun to 41).
REQ-029 Frame_Done and Frame_Error SHALL never be high in the same cycle.
REQ-030 MISO SHALL be 0 whenever the state is IDLE or REPORT.
REQ-031 SCLK edges while SS is high SHALL be ignored.
REQ-032 An SS rising edge and an SCLK edge in the same synchronized cycle: SS SHALL take priority; that SCLK edge is ignored.
REQ-033 An SS falling edge arriving while in REPORT SHALL be acted on in the IDLE cycle that follows; the new frame SHALL still be captured.
REQ-034 Latency from a pin-level SCLK or SS edge to the internal action SHALL be exactly 3 Clk cycles.

Reset
REQ-035 Reset SHALL set: state = IDLE, MISO = 0, Led_Cmd = 2'b00, Frame_Done = 0, Frame_Error = 0, bit counter = 0, TX and RX registers = 0, synchronizers = SS high and SCLK/MOSI low.
REQ-036 Reset asserted mid-frame SHALL abort the frame without any Frame_Done or Frame_Error pulse.
REQ-037 After a mid-frame reset, SS must return high and fall again before the next frame is accepted.

Verification
REQ-038 Normal frame: X_Pos=10'h2A5, Y_Pos=10'h13C, Buttons=3'b101, master sends 8'h82 then 32 zero bits at SCLK = Clk/10 -> master receives A5 02 3C 01 05; Led_Cmd=2'b10; one Frame_Done pulse.
REQ-039 No LED command: first byte 8'h03 -> Led_Cmd holds its previous value; Frame_Done pulses.
REQ-040 Short frame: SS deasserted after 20 bits -> Frame_Error pulses once; no Frame_Done; MISO=0 afterwards.
REQ-041 Overrun: 44 SCLK pulses -> bits 41-44 on MISO are 0; Frame_Error pulses.
REQ-042 Snapshot isolation: change X_Pos to 10'h000 at bit 4 of a frame started with 10'h3FF -> received bytes 1-2 are FF 03.
REQ-043 Reset at bit 16 -> MISO=0 and Led_Cmd=00 on the next cycle, no pulses; the next full frame completes with Frame_Done.

Source files
------------

// File: rtl/jstk_spi_responder_if.sv
// rtl/jstk_spi_responder_if.sv - SPI pin bundle between a joystick-style SPI master and the responder
interface jstk_spi_responder_if;
    logic SS;
    logic SCLK;
    logic MOSI;
    logic MISO;

    modport master (output SS, output SCLK, output MOSI, input MISO);
    modport slave  (input SS, input SCLK, input MOSI, output MISO);
endinterface

// File: rtl/jstk_spi_responder.sv
// rtl/jstk_spi_responder.sv - SPI mode-0 slave reporting X/Y/buttons in a 40-bit frame and accepting LED commands
module jstk_spi_responder (
    input  logic                       Clk,
    input  logic                       Reset,
    jstk_spi_responder_if.slave        spi,
    input  logic [9:0]                 X_Pos,
    input  logic [9:0]                 Y_Pos,
    input  logic [2:0]                 Buttons,
    output logic [1:0]                 Led_Cmd,
    output logic                       Frame_Done,
    output logic                       Frame_Error
);

    typedef enum logic [1:0] {IDLE, SHIFT, REPORT} state_t;

    // Synchronizer chains: meta -> sync -> prev (prev is the edge-detect stage)
    logic ss_meta_q, ss_sync_q, ss_prev_q;
    logic sclk_meta_q, sclk_sync_q, sclk_prev_q;
    logic mosi_meta_q, mosi_sync_q, mosi_prev_q;
    // Tracks how far real pin samples have propagated since reset, so the
    // reset values of the SS chain are never mistaken for a sampled high.
    logic [2:0] vld_q;

    state_t      state_q, state_d;
    logic [39:0] tx_q, tx_d;
    logic [7:0]  rx_q, rx_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        miso_q, miso_d;
    logic [1:0]  led_q, led_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        pend_q, pend_d;
    logic        armed_q, armed_d;

    logic        ss_fall, ss_rise, sclk_rise, sclk_fall;
    logic [39:0] frame;

    assign ss_fall   =  ss_prev_q   & ~ss_sync_q;
    assign ss_rise   = ~ss_prev_q   &  ss_sync_q;
    assign sclk_rise = ~sclk_prev_q &  sclk_sync_q;
    assign sclk_fall =  sclk_prev_q & ~sclk_sync_q;

    assign frame = {X_Pos[7:0], 6'b0, X_Pos[9:8], Y_Pos[7:0], 6'b0, Y_Pos[9:8], 5'b0, Buttons};

    assign spi.MISO    = miso_q;
    assign Led_Cmd     = led_q;
    assign Frame_Done  = done_q;
    assign Frame_Error = err_q;

    // Bring the asynchronous SPI pins into the Clk domain and delay once more for edge detection
    always_ff @(posedge Clk) begin
        if (Reset) begin
            ss_meta_q   <= 1'b1;
            ss_sync_q   <= 1'b1;
            ss_prev_q   <= 1'b1;
            sclk_meta_q <= 1'b0;
            sclk_sync_q <= 1'b0;
            sclk_prev_q <= 1'b0;
            mosi_meta_q <= 1'b0;
            mosi_sync_q <= 1'b0;
            mosi_prev_q <= 1'b0;
            vld_q       <= 3'b000;
        end else begin
            ss_meta_q   <= spi.SS;
            ss_sync_q   <= ss_meta_q;
            ss_prev_q   <= ss_sync_q;
            sclk_meta_q <= spi.SCLK;
            sclk_sync_q <= sclk_meta_q;
            sclk_prev_q <= sclk_sync_q;
            mosi_meta_q <= spi.MOSI;
            mosi_sync_q <= mosi_meta_q;
            mosi_prev_q <= mosi_sync_q;
            vld_q       <= {vld_q[1:0], 1'b1};
        end
    end

    // Next-state logic: frame capture, bit shifting, LED command decode and end-of-frame reporting
    always_comb begin
        state_d = state_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        cnt_d   = cnt_q;
        miso_d  = miso_q;
        led_d   = led_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        pend_d  = pend_q;
        // Armed only once SS has genuinely been seen high after reset
        armed_d = armed_q | (vld_q[2] & ss_prev_q & ss_sync_q);

        // First byte complete: a set command bit loads the LED field; rx is frozen from here on
        if (cnt_q == 6'd8 && rx_q[7]) begin
            led_d = rx_q[1:0];
        end

        case (state_q)
            IDLE: begin
                miso_d = 1'b0;
                if ((ss_fall && armed_q) || pend_q) begin
                    state_d = SHIFT;
                    tx_d    = frame;
                    rx_d    = 8'h00;
                    cnt_d   = 6'd0;
                    miso_d  = frame[39];
                    pend_d  = 1'b0;
                end
            end
            SHIFT: begin
                // SS release wins over any coincident SCLK edge
                if (ss_rise) begin
                    state_d = REPORT;
                    miso_d  = 1'b0;
                end else if (sclk_rise) begin
                    if (cnt_q < 6'd8) begin
                        rx_d = {rx_q[6:0], mosi_prev_q};
                    end
                    if (cnt_q < 6'd41) begin
                        cnt_d = cnt_q + 6'd1;
                    end
                end else if (sclk_fall) begin
                    tx_d   = {tx_q[38:0], 1'b0};
                    miso_d = tx_q[38];
                end
            end
            REPORT: begin
                miso_d  = 1'b0;
                done_d  = (cnt_q == 6'd40);
                err_d   = (cnt_q != 6'd40);
                state_d = IDLE;
                // A new frame starting during the report cycle is remembered for IDLE
                if (ss_fall) begin
                    pend_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                miso_d  = 1'b0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            tx_q    <= 40'd0;
            rx_q    <= 8'd0;
            cnt_q   <= 6'd0;
            miso_q  <= 1'b0;
            led_q   <= 2'b00;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            pend_q  <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            cnt_q   <= cnt_d;
            miso_q  <= miso_d;
            led_q   <= led_d;
            done_q  <= done_d;
            err_q   <= err_d;
            pend_q  <= pend_d;
            armed_q <= armed_d;
        end
    end

endmodule

// File: tb/tb_jstk_spi_responder.sv
// tb/tb_jstk_spi_responder.sv - directed vector bench for jstk_spi_responder
module tb_jstk_spi_responder;

    logic       clk;
    logic       reset;
    logic [9:0] x_pos;
    logic [9:0] y_pos;
    logic [2:0] buttons;
    logic [1:0] led_cmd;
    logic       frame_done;
    logic       frame_error;

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;
    int err_cnt  = 0;
    bit both_hi  = 1'b0;

    jstk_spi_responder_if spi();

    jstk_spi_responder dut (
        .Clk         (clk),
        .Reset       (reset),
        .spi         (spi),
        .X_Pos       (x_pos),
        .Y_Pos       (y_pos),
        .Buttons     (buttons),
        .Led_Cmd     (led_cmd),
        .Frame_Done  (frame_done),
        .Frame_Error (frame_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_done)  done_cnt++;
        if (frame_error) err_cnt++;
        if (frame_done && frame_error) both_hi = 1'b1;
    end

    typedef struct {
        logic [9:0]  x;
        logic [9:0]  y;
        logic [2:0]  b;
        logic [7:0]  fb;
        int          nbits;
        int          chg_at;
        logic [63:0] exp_rx;
        logic [1:0]  exp_led;
        int          exp_done;
        int          exp_err;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic spi_xfer(input int nbits, input logic [7:0] fb, input int chg_at,
                            input bit raise, output logic [63:0] rx);
        logic [7:0] b;
        b  = fb;
        rx = 64'd0;
        spi.SS = 1'b0;
        repeat (5) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            if (i == chg_at) x_pos = 10'h000;
            spi.MOSI = (i < 8) ? b[3'(7 - i)] : 1'b0;
            repeat (5) @(negedge clk);
            spi.SCLK = 1'b1;
            rx = {rx[62:0], spi.MISO};
            repeat (5) @(negedge clk);
            spi.SCLK = 1'b0;
        end
        spi.MOSI = 1'b0;
        if (raise) begin
            repeat (5) @(negedge clk);
            spi.SS = 1'b1;
            repeat (8) @(negedge clk);
        end
    endtask

    initial begin
        logic [63:0] rx;
        int          d0, e0;
        bit          miso_seen;

        vecs[0] = '{10'h2A5, 10'h13C, 3'b101, 8'h82, 40, -1, 64'hA5023C0105,  2'b10, 1, 0};
        vecs[1] = '{10'h155, 10'h2AA, 3'b010, 8'h03, 40, -1, 64'h5501AA0202,  2'b10, 1, 0};
        vecs[2] = '{10'h3FF, 10'h000, 3'b000, 8'h81, 20, -1, 64'hFF030,       2'b01, 0, 1};
        vecs[3] = '{10'h001, 10'h3FF, 3'b111, 8'h80, 44, -1, 64'h0100FF03070, 2'b00, 0, 1};
        vecs[4] = '{10'h000, 10'h000, 3'b001, 8'hC3, 40, -1, 64'h0000000001,  2'b11, 1, 0};
        vecs[5] = '{10'h200, 10'h100, 3'b100, 8'hFE, 39, -1, 64'h0001000082,  2'b10, 0, 1};
        vecs[6] = '{10'h3FF, 10'h000, 3'b000, 8'h00, 40,  4, 64'hFF03000000,  2'b10, 1, 0};

        reset    = 1'b1;
        spi.SS   = 1'b1;
        spi.SCLK = 1'b0;
        spi.MOSI = 1'b0;
        x_pos    = 10'h000;
        y_pos    = 10'h000;
        buttons  = 3'b000;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset_miso", spi.MISO, 0);
        check("reset_led", led_cmd, 0);
        check("reset_done", frame_done, 0);
        check("reset_err", frame_error, 0);
        repeat (10) @(negedge clk);

        for (int v = 0; v < 7; v++) begin
            x_pos   = vecs[v].x;
            y_pos   = vecs[v].y;
            buttons = vecs[v].b;
            @(negedge clk);
            d0 = done_cnt;
            e0 = err_cnt;
            spi_xfer(vecs[v].nbits, vecs[v].fb, vecs[v].chg_at, 1'b1, rx);
            check($sformatf("v%0d_rx", v), rx, vecs[v].exp_rx);
            check($sformatf("v%0d_led", v), led_cmd, vecs[v].exp_led);
            check($sformatf("v%0d_done", v), done_cnt - d0, vecs[v].exp_done);
            check($sformatf("v%0d_err", v), err_cnt - e0, vecs[v].exp_err);
            check($sformatf("v%0d_miso_after", v), spi.MISO, 0);
        end

        // Reset at bit 16 of a frame, then SS held low: no frame may start until SS cycles
        x_pos   = 10'h2A5;
        y_pos   = 10'h13C;
        buttons = 3'b101;
        d0 = done_cnt;
        e0 = err_cnt;
        spi_xfer(16, 8'h81, -1, 1'b0, rx);
        check("rst_pre_led", led_cmd, 2'b01);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst_miso", spi.MISO, 0);
        check("rst_led", led_cmd, 0);
        miso_seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (spi.MISO !== 1'b0) miso_seen = 1'b1;
        end
        check("rst_no_restart", miso_seen, 0);
        spi.SS = 1'b1;
        repeat (8) @(negedge clk);
        check("rst_no_pulse_done", done_cnt - d0, 0);
        check("rst_no_pulse_err", err_cnt - e0, 0);
        spi_xfer(40, 8'h82, -1, 1'b1, rx);
        check("rst_next_rx", rx, 64'hA5023C0105);
        check("rst_next_done", done_cnt - d0, 1);
        check("rst_next_err", err_cnt - e0, 0);
        check("rst_next_led", led_cmd, 2'b10);

        // SS pulses high for one cycle: the refall lands in the report cycle
        x_pos   = 10'h155;
        y_pos   = 10'h2AA;
        buttons = 3'b010;
        d0 = done_cnt;
        e0 = err_cnt;
        spi_xfer(40, 8'h00, -1, 1'b0, rx);
        check("b2b_rx0", rx, 64'h5501AA0202);
        repeat (5) @(negedge clk);
        spi.SS = 1'b1;
        @(negedge clk);
        spi_xfer(40, 8'h00, -1, 1'b1, rx);
        check("b2b_rx1", rx, 64'h5501AA0202);
        check("b2b_done", done_cnt - d0, 2);
        check("b2b_err", err_cnt - e0, 0);

        // SCLK toggling with SS high is ignored
        d0 = done_cnt;
        e0 = err_cnt;
        miso_seen = 1'b0;
        spi.MOSI = 1'b1;
        for (int i = 0; i < 12; i++) begin
            spi.SCLK = ~spi.SCLK;
            repeat (5) @(negedge clk);
            if (spi.MISO !== 1'b0) miso_seen = 1'b1;
        end
        spi.MOSI = 1'b0;
        check("idle_sclk_miso", miso_seen, 0);
        check("idle_sclk_pulses", (done_cnt - d0) + (err_cnt - e0), 0);
        check("idle_sclk_led", led_cmd, 2'b10);

        check("never_both_pulses", both_hi, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
